// File: rtl/multi_seq_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package multi_seq_pkg;

  localparam int unsigned WIDTH          = 32;
  localparam int unsigned PWIDTH         = 64;
  localparam int unsigned FIX_LAT_CYCLES = 32;

  typedef enum logic [1:0] {NOP, ADD, SUB} digit_e;
  typedef enum logic       {IDLE, BUSY}    state_e;

  // Radix-2 Booth digit from the pair (b[i], b[i-1]).
  function automatic digit_e booth_op(input logic [1:0] pair);
    case (pair)
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/multi_seq_booth_next_digit.sv
// Priority encoder selecting the lowest unprocessed nonzero Booth digit.
module booth_next_digit
  import multi_seq_pkg::*;
#(
  parameter int unsigned WIDTH = multi_seq_pkg::WIDTH,
  localparam int unsigned IW   = $clog2(WIDTH)
) (
  input  logic [WIDTH:0]   mlier_ext,
  input  logic [WIDTH-1:0] done,
  output logic             found,
  output logic [IW-1:0]    index,
  output digit_e           op,
  output logic             last
);

  logic [WIDTH-1:0] nz;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] lowest;

  always_comb begin
    nz    = '0;
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      nz[i] = mlier_ext[i+1] ^ mlier_ext[i];
    end
    cand   = nz & ~done;
    lowest = cand & (~cand + WIDTH'(1));
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (lowest[i]) begin
        index = IW'(i);
      end
    end
    found = |cand;
    last  = ((cand & ~lowest) == '0);
    op    = found ? booth_op(mlier_ext[index +: 2]) : NOP;
  end

endmodule

// File: rtl/multi_seq.sv
// Sequential signed Booth multiplier, fixed (FIX_LT=1) or zero-skipping (FIX_LT=0) latency.
module multi_seq #(
  parameter int unsigned FIX_LT = 1,
  parameter int unsigned WIDTH  = multi_seq_pkg::WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mlier,
  input  logic [WIDTH-1:0]     mcand,
  output logic [2*WIDTH-1:0]   prodt,
  input  logic                 start,
  output logic                 valid
);
  import multi_seq_pkg::*;

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = $clog2(WIDTH);

  state_e          state_q, state_d;
  logic            start_q, start_d;
  logic [WIDTH-1:0] mlier_q, mlier_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prodt_q, prodt_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   cnt_q, cnt_d;

  logic            capture;
  logic            busy;
  logic [WIDTH:0]  mlier_ext;
  logic [IW-1:0]   dig_idx;
  digit_e          dig_op;
  logic            complete;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_step;

  assign capture   = start && !start_q && (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign mlier_ext = {mlier_q, 1'b0};

  if (FIX_LT != 0) begin : g_fixed
    assign dig_idx  = cnt_q;
    assign dig_op   = booth_op(mlier_ext[cnt_q +: 2]);
    assign complete = (cnt_q == IW'(FIX_LAT_CYCLES - 1));
  end else begin : g_var
    localparam logic [WIDTH-1:0] ONES = '1;
    logic             found;
    logic             last;
    logic [WIDTH-1:0] done_q, done_d;

    booth_next_digit #(.WIDTH(WIDTH)) u_next (
      .mlier_ext (mlier_ext),
      .done      (done_q),
      .found     (found),
      .index     (dig_idx),
      .op        (dig_op),
      .last      (last)
    );

    // The step-count cap never changes the result: a 32nd step is always the last digit.
    assign complete = !found || last || (cnt_q == IW'(WIDTH - 1));

    always_comb begin
      done_d = done_q;
      if (capture) begin
        done_d = '0;
      end else if (busy && found) begin
        done_d = done_q | (ONES >> (IW'(WIDTH - 1) - dig_idx));
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        done_q <= '0;
      end else begin
        done_q <= done_d;
      end
    end
  end

  assign addend = mcand_q << dig_idx;

  always_comb begin
    state_d = state_q;
    start_d = start;
    mlier_d = mlier_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    prodt_d = prodt_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    case (dig_op)
      ADD:     acc_step = acc_q + addend;
      SUB:     acc_step = acc_q - addend;
      default: acc_step = acc_q;
    endcase
    case (state_q)
      IDLE: begin
        if (capture) begin
          mlier_d = mlier;
          mcand_d = {{WIDTH{mcand[WIDTH-1]}}, mcand};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + IW'(1);
        if (complete) begin
          prodt_d = acc_step;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      mlier_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      prodt_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mlier_q <= mlier_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      prodt_q <= prodt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prodt = prodt_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_multi_seq.sv
// Directed bench for both latency builds of multi_seq driven side by side.
module tb_multi_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mlier = '0;
  logic [31:0] mcand = '0;
  logic        start = 1'b0;
  logic [63:0] prodt_f, prodt_v;
  logic        valid_f, valid_v;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  multi_seq #(.FIX_LT(1), .WIDTH(32)) u_fix (
    .clock (clock), .reset (reset), .mlier (mlier), .mcand (mcand),
    .prodt (prodt_f), .start (start), .valid (valid_f)
  );

  multi_seq #(.FIX_LT(0), .WIDTH(32)) u_var (
    .clock (clock), .reset (reset), .mlier (mlier), .mcand (mcand),
    .prodt (prodt_v), .start (start), .valid (valid_v)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          lv;
  } vec_t;

  // One operation: start high from before E0 through E33, then low for two cycles.
  // Latency 0 means valid was never seen within the bound.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         output int lat_f, output int lat_v,
                         output int nv_f, output int nv_v,
                         output logic [63:0] p_f, output logic [63:0] p_v,
                         output logic [63:0] mid_f, output logic [63:0] mid_v);
    lat_f = 0; lat_v = 0; nv_f = 0; nv_v = 0;
    p_f = '0; p_v = '0; mid_f = '0; mid_v = '0;
    @(negedge clock);
    mlier = a;
    mcand = b;
    start = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 33; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) begin
        mid_f = prodt_f;
        mid_v = prodt_v;
        mlier = ~a;
        mcand = ~b;
      end
      if (valid_f) begin
        nv_f++;
        if (lat_f == 0) begin lat_f = c; p_f = prodt_f; end
      end
      if (valid_v) begin
        nv_v++;
        if (lat_v == 0) begin lat_v = c; p_v = prodt_v; end
      end
    end
    start = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (prodt_f !== 64'h0 || valid_f !== 1'b0) begin
      failures++;
      $display("FAIL reset_fix: prodt=%h valid=%b expected prodt=0 valid=0", prodt_f, valid_f);
    end
    checks++;
    if (prodt_v !== 64'h0 || valid_v !== 1'b0) begin
      failures++;
      $display("FAIL reset_var: prodt=%h valid=%b expected prodt=0 valid=0", prodt_v, valid_v);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_products();
    vec_t vecs[9];
    int lf, lv, nf, nv;
    logic [63:0] pf, pv, mf, mv;
    vecs[0] = '{32'h55555555, 32'h00000001, 64'h0000000055555555, 32};
    vecs[1] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 1};
    vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, 1};
    vecs[4] = '{32'h00000001, 32'h80000000, 64'hFFFFFFFF80000000, 2};
    vecs[5] = '{32'h00000000, 32'h7FFFFFFF, 64'h0000000000000000, 1};
    vecs[6] = '{32'h7FFFFFFF, 32'h00000000, 64'h0000000000000000, 2};
    vecs[7] = '{32'h0000000C, 32'h00000005, 64'h000000000000003C, 2};
    vecs[8] = '{32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB, 3};
    for (int i = 0; i < 9; i++) begin
      do_mult(vecs[i].a, vecs[i].b, lf, lv, nf, nv, pf, pv, mf, mv);
      checks++;
      if (lf != 32) begin
        failures++;
        $display("FAIL lat_fix[%0d]: got %0d expected 32", i, lf);
      end
      checks++;
      if (lv != vecs[i].lv) begin
        failures++;
        $display("FAIL lat_var[%0d]: got %0d expected %0d", i, lv, vecs[i].lv);
      end
      checks++;
      if (pf !== vecs[i].p) begin
        failures++;
        $display("FAIL prod_fix[%0d]: got %h expected %h", i, pf, vecs[i].p);
      end
      checks++;
      if (pv !== vecs[i].p) begin
        failures++;
        $display("FAIL prod_var[%0d]: got %h expected %h", i, pv, vecs[i].p);
      end
      checks++;
      if (nf != 1 || nv != 1) begin
        failures++;
        $display("FAIL valid_count[%0d]: got fix=%0d var=%0d expected 1 and 1", i, nf, nv);
      end
    end
  endtask

  task automatic test_hold();
    int lf, lv, nf, nv;
    logic [63:0] pf, pv, mf, mv;
    do_mult(32'h55555555, 32'h00000003, lf, lv, nf, nv, pf, pv, mf, mv);
    checks++;
    if (mf !== 64'hFFFFFFFFFFFFFFEB || mv !== 64'hFFFFFFFFFFFFFFEB) begin
      failures++;
      $display("FAIL hold_busy: got fix=%h var=%h expected ffffffffffffffeb", mf, mv);
    end
    checks++;
    if (pf !== 64'h00000000FFFFFFFF || pv !== 64'h00000000FFFFFFFF) begin
      failures++;
      $display("FAIL hold_result: got fix=%h var=%h expected 00000000ffffffff", pf, pv);
    end
  endtask

  task automatic test_rearm();
    int nf, nv, lf, lv;
    logic [63:0] pf, pv;
    nf = 0; nv = 0;
    @(negedge clock);
    mlier = 32'h00000002;
    mcand = 32'h00000003;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (valid_f) nf++;
      if (valid_v) nv++;
    end
    checks++;
    if (nf != 1 || nv != 1) begin
      failures++;
      $display("FAIL held_start: got fix=%0d var=%0d valids expected 1 and 1", nf, nv);
    end
    checks++;
    if (prodt_f !== 64'h6 || prodt_v !== 64'h6) begin
      failures++;
      $display("FAIL held_prod: got fix=%h var=%h expected 6", prodt_f, prodt_v);
    end
    start = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b1;
    mlier = 32'hFFFFFFFC;
    mcand = 32'h00000009;
    @(posedge clock);
    lf = 0; lv = 0; pf = '0; pv = '0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clock);
      #1;
      if (valid_f && lf == 0) begin lf = c; pf = prodt_f; end
      if (valid_v && lv == 0) begin lv = c; pv = prodt_v; end
    end
    start = 1'b0;
    repeat (2) @(posedge clock);
    checks++;
    if (lf != 32 || lv != 1) begin
      failures++;
      $display("FAIL rearm_lat: got fix=%0d var=%0d expected 32 and 1", lf, lv);
    end
    checks++;
    if (pf !== 64'hFFFFFFFFFFFFFFDC || pv !== 64'hFFFFFFFFFFFFFFDC) begin
      failures++;
      $display("FAIL rearm_prod: got fix=%h var=%h expected ffffffffffffffdc", pf, pv);
    end
  endtask

  task automatic test_abort();
    int lf, lv, nf, nv;
    logic [63:0] pf, pv, mf, mv;
    @(negedge clock);
    mlier = 32'h55555555;
    mcand = 32'h00000003;
    start = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (prodt_f !== 64'h0 || valid_f !== 1'b0) begin
      failures++;
      $display("FAIL abort_fix: prodt=%h valid=%b expected prodt=0 valid=0", prodt_f, valid_f);
    end
    checks++;
    if (prodt_v !== 64'h0 || valid_v !== 1'b0) begin
      failures++;
      $display("FAIL abort_var: prodt=%h valid=%b expected prodt=0 valid=0", prodt_v, valid_v);
    end
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    do_mult(32'h00010000, 32'h00010000, lf, lv, nf, nv, pf, pv, mf, mv);
    checks++;
    if (pf !== 64'h0000000100000000 || pv !== 64'h0000000100000000) begin
      failures++;
      $display("FAIL after_abort_prod: got fix=%h var=%h expected 0000000100000000", pf, pv);
    end
    checks++;
    if (lf != 32 || lv != 2 || nf != 1 || nv != 1) begin
      failures++;
      $display("FAIL after_abort_lat: got fix=%0d/%0d var=%0d/%0d expected 32/1 and 2/1",
               lf, nf, lv, nv);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_hold();
    test_rearm();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
